// File: rtl/soc_decerr_slave_pkg.sv
// Shared definitions for the AXI4 decode-error slave: response encoding,
// default read data pattern and the write/read FSM state types.
package soc_decerr_slave_pkg;

  // AXI DECERR response encoding.
  localparam logic [1:0]  RESP_DECERR      = 2'b11;

  // Recognisable pattern returned on every read from an unmapped hole.
  localparam logic [63:0] DEFAULT_ERR_DATA = 64'hBADC_AB1E_BADC_AB1E;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/soc_decerr_slave.sv
// AXI4 error-response slave for the unmapped region of the SoC crossbar.
// Every write is answered with a single DECERR B; every read burst is
// answered with len+1 DECERR beats carrying ERR_DATA. The read and write
// channels are independent and each holds one transaction at a time.
// Optional macro SOC_DECERR_CAPTURE_EN adds a sticky first-fault address
// capture (err_valid_o / err_addr_o, cleared by err_clear_i).
//
// Handshake semantics: a transfer happens on a rising clk_i edge where both
// valid and ready are 1. All ready/valid/payload outputs come straight from
// registers, so nothing here depends combinationally on an input, and a
// raised valid keeps its payload until the matching ready is seen.
module soc_decerr_slave
  import soc_decerr_slave_pkg::*;
#(
  parameter int unsigned           ID_WIDTH   = 5,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(DEFAULT_ERR_DATA)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef SOC_DECERR_CAPTURE_EN
  input  logic                  err_clear_i,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
`endif
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  w_last_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]            b_resp_o,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o
);

  // Write channel state
  w_state_e            w_state_q;
  logic                aw_ready_q;
  logic                w_ready_q;
  logic                b_valid_q;
  logic [ID_WIDTH-1:0] b_id_q;

  // Read channel state
  r_state_e            r_state_q;
  logic                ar_ready_q;
  logic                r_valid_q;
  logic                r_last_q;
  logic [ID_WIDTH-1:0] r_id_q;
  logic [7:0]          r_len_q;
  logic [7:0]          r_cnt_q;
  logic [7:0]          r_cnt_d;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;

  assign aw_hs   = aw_valid_i & aw_ready_q;
  assign w_hs    = w_valid_i  & w_ready_q;
  assign b_hs    = b_valid_q  & b_ready_i;
  assign ar_hs   = ar_valid_i & ar_ready_q;
  assign r_hs    = r_valid_q  & r_ready_i;
  assign r_cnt_d = r_cnt_q + 8'd1;

  // Write FSM: take AW, swallow W beats until WLAST, then return one DECERR B.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          // Ready comes up on the first cycle out of reset and stays up.
          aw_ready_q <= 1'b1;
          if (aw_hs) begin
            w_state_q  <= W_DATA;
            b_id_q     <= aw_id_i;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
          end
        end
        W_DATA: begin
          // Burst length is not tracked: WLAST alone closes the burst.
          if (w_hs && w_last_i) begin
            w_state_q <= W_RESP;
            w_ready_q <= 1'b0;
            b_valid_q <= 1'b1;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            w_state_q  <= W_IDLE;
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
          end
        end
        default: begin
          w_state_q  <= W_IDLE;
          aw_ready_q <= 1'b0;
          w_ready_q  <= 1'b0;
          b_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: take AR, then stream len+1 DECERR beats with RLAST on the final one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          ar_ready_q <= 1'b1;
          if (ar_hs) begin
            r_state_q  <= R_DATA;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b1;
            r_id_q     <= ar_id_i;
            r_len_q    <= ar_len_i;
            r_cnt_q    <= '0;
            r_last_q   <= (ar_len_i == 8'd0);
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (r_last_q) begin
              // Counter stops at len, so len=255 never needs to wrap.
              r_state_q  <= R_IDLE;
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
            end else begin
              r_cnt_q  <= r_cnt_d;
              r_last_q <= (r_cnt_d == r_len_q);
            end
          end
        end
        default: begin
          r_state_q  <= R_IDLE;
          ar_ready_q <= 1'b0;
          r_valid_q  <= 1'b0;
          r_last_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef SOC_DECERR_CAPTURE_EN
  logic                  err_valid_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  // Sticky first-fault capture; a new fault in the clearing cycle is kept, AW beats AR.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if ((!err_valid_q || err_clear_i) && (aw_hs || ar_hs)) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= aw_hs ? aw_addr_i : ar_addr_i;
    end else if (err_clear_i) begin
      err_valid_q <= 1'b0;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
`else
  // Addresses only matter for fault capture.
  logic unused_addr;
  assign unused_addr = ^{aw_addr_i, ar_addr_i};
`endif

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_id_o     = b_id_q;
  assign b_resp_o   = RESP_DECERR;

  assign ar_ready_o = ar_ready_q;
  assign r_valid_o  = r_valid_q;
  assign r_id_o     = r_id_q;
  assign r_data_o   = r_valid_q ? ERR_DATA : '0;
  assign r_resp_o   = RESP_DECERR;
  assign r_last_o   = r_last_q;

endmodule

// File: tb/tb_soc_decerr_slave.sv
// Testbench for soc_decerr_slave: cycle table, directed corner sequences,
// randomized traffic, and a negedge scoreboard built on transaction queues.
module tb_soc_decerr_slave;

  localparam int          IDW = 5;
  localparam int          DW  = 64;
  localparam int          AW  = 64;
  localparam logic [63:0] ERR = 64'hBADC_AB1E_BADC_AB1E;

  // ---------------- clock / reset / DUT ----------------
  logic           clk;
  logic           rst;
  logic           aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic           b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [IDW-1:0] aw_id, b_id, ar_id, r_id;
  logic [AW-1:0]  aw_addr, ar_addr;
  logic [7:0]     ar_len;
  logic [1:0]     b_resp, r_resp;
  logic [DW-1:0]  r_data;
`ifdef SOC_DECERR_CAPTURE_EN
  logic           err_clear, err_valid;
  logic [AW-1:0]  err_addr;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  soc_decerr_slave #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
`ifdef SOC_DECERR_CAPTURE_EN
    .err_clear_i(err_clear),
    .err_valid_o(err_valid),
    .err_addr_o (err_addr),
`endif
    .aw_valid_i (aw_valid),
    .aw_ready_o (aw_ready),
    .aw_id_i    (aw_id),
    .aw_addr_i  (aw_addr),
    .w_valid_i  (w_valid),
    .w_ready_o  (w_ready),
    .w_last_i   (w_last),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .b_id_o     (b_id),
    .b_resp_o   (b_resp),
    .ar_valid_i (ar_valid),
    .ar_ready_o (ar_ready),
    .ar_id_i    (ar_id),
    .ar_addr_i  (ar_addr),
    .ar_len_i   (ar_len),
    .r_valid_o  (r_valid),
    .r_ready_i  (r_ready),
    .r_id_o     (r_id),
    .r_data_o   (r_data),
    .r_resp_o   (r_resp),
    .r_last_o   (r_last)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Expected B ids and expected R beats ({id, last}) in order.
  logic [IDW-1:0] b_exp_q[$];
  logic [IDW:0]   exp_q[$];
  bit             w_open = 1'b0;  // AW taken, WLAST not yet seen
  bit             fresh  = 1'b1;  // first cycle out of reset

  always @(negedge clk) begin
    if (rst) begin
      b_exp_q.delete();
      exp_q.delete();
      w_open = 1'b0;
      fresh  = 1'b1;
      check("rst_handshakes", {aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last}, 6'b0);
      check("rst_ids", {b_id, r_id}, '0);
      check("rst_data", r_data, 64'h0);
      check("rst_resp", {b_resp, r_resp}, 4'hF);
    end else begin
      check("aw_ready", aw_ready, !fresh && (b_exp_q.size() == 0));
      check("w_ready", w_ready, w_open);
      check("b_valid", b_valid, (b_exp_q.size() != 0) && !w_open);
      check("ar_ready", ar_ready, !fresh && (exp_q.size() == 0));
      check("r_valid", r_valid, exp_q.size() != 0);

      if (b_valid && b_exp_q.size() != 0) begin
        check("b_id", b_id, b_exp_q[0]);
        check("b_resp", b_resp, 2'b11);
        if (b_ready) void'(b_exp_q.pop_front());
      end
      if (r_valid && exp_q.size() != 0) begin
        check("r_id", r_id, exp_q[0][IDW:1]);
        check("r_last", r_last, exp_q[0][0]);
        check("r_data", r_data, ERR);
        check("r_resp", r_resp, 2'b11);
        if (r_ready) void'(exp_q.pop_front());
      end
      if (aw_valid && aw_ready) begin
        b_exp_q.push_back(aw_id);
        w_open = 1'b1;
      end
      if (w_valid && w_ready && w_last) w_open = 1'b0;
      if (ar_valid && ar_ready) begin
        for (int i = 0; i <= int'(ar_len); i++) exp_q.push_back({ar_id, i == int'(ar_len)});
      end
      fresh = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
    ar_valid = 1'b0; r_ready = 1'b0; ar_len = 8'd0;
`ifdef SOC_DECERR_CAPTURE_EN
    err_clear = 1'b0;
`endif
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Cycle table: outputs expected this cycle, then inputs driven for it.
  // drv = {aw_v, w_v, w_last, b_ready, ar_v, r_ready}
  // exp = {aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last}
  typedef struct {
    logic [5:0] drv;
    logic [7:0] len;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[16];

  task automatic run_table();
    vecs[0]  = '{6'b011000, 8'd0, 6'b100100};  // W before AW: must not be taken
    vecs[1]  = '{6'b100000, 8'd0, 6'b100100};
    vecs[2]  = '{6'b010000, 8'd0, 6'b010100};
    vecs[3]  = '{6'b010000, 8'd0, 6'b010100};
    vecs[4]  = '{6'b010000, 8'd0, 6'b010100};
    vecs[5]  = '{6'b011000, 8'd0, 6'b010100};  // beat 4 with WLAST
    vecs[6]  = '{6'b000000, 8'd0, 6'b001100};
    vecs[7]  = '{6'b000100, 8'd0, 6'b001100};
    vecs[8]  = '{6'b000010, 8'd1, 6'b100100};
    vecs[9]  = '{6'b000000, 8'd0, 6'b100010};
    vecs[10] = '{6'b000001, 8'd0, 6'b100010};
    vecs[11] = '{6'b000001, 8'd0, 6'b100011};
    vecs[12] = '{6'b100010, 8'd0, 6'b100100};  // AW and AR together
    vecs[13] = '{6'b011001, 8'd0, 6'b010011};
    vecs[14] = '{6'b000100, 8'd0, 6'b001100};
    vecs[15] = '{6'b000000, 8'd0, 6'b100100};
    aw_id = 5'h13; aw_addr = 64'h0000_5000;
    ar_id = 5'h02; ar_addr = 64'h0000_6000;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("vec%0d", i), {aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last}, vecs[i].exp);
      if (vecs[i].exp[3]) check("vec_b_id", b_id, 5'h13);
      if (vecs[i].exp[1]) check("vec_r_id", r_id, 5'h02);
      {aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready} = vecs[i].drv;
      ar_len = vecs[i].len;
    end
    idle_inputs();
    tick();
  endtask

  task automatic read_len7();
    ar_valid = 1'b1; ar_id = 5'h02; ar_len = 8'd7; r_ready = 1'b1;
    tick();
    ar_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("len7_valid", r_valid, 1'b1);
      check("len7_last", r_last, i == 7);
      check("len7_data", r_data, ERR);
      tick();
    end
    check("len7_done_valid", r_valid, 1'b0);
    check("len7_done_ready", ar_ready, 1'b1);
    idle_inputs();
  endtask

  task automatic read_len255();
    int beats = 0;
    bit early = 1'b0;
    ar_valid = 1'b1; ar_id = 5'($urandom_range(0, 31)); ar_len = 8'd255;
    tick();
    ar_valid = 1'b0;
    for (int c = 0; c < 3000 && beats < 256; c++) begin
      if (ar_ready) early = 1'b1;
      r_ready = ($urandom_range(0, 2) != 0);
      if (r_valid && r_ready) beats++;
      tick();
    end
    check("len255_beats", beats, 256);
    check("len255_ar_early", early, 1'b0);
    check("len255_ar_back", ar_ready, 1'b1);
    check("len255_r_idle", r_valid, 1'b0);
    idle_inputs();
  endtask

  task automatic aw_ar_together();
    aw_valid = 1'b1; aw_id = 5'd1; ar_valid = 1'b1; ar_id = 5'd2; ar_len = 8'd3;
    r_ready = 1'b1; b_ready = 1'b0;
    tick();
    check("sim_aw_taken", aw_ready, 1'b0);
    check("sim_ar_taken", ar_ready, 1'b0);
    aw_valid = 1'b0; ar_valid = 1'b0; w_valid = 1'b1; w_last = 1'b1;
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("sim_b_held", {b_valid, b_id}, {1'b1, 5'd1});
      tick();
    end
    check("sim_read_done", {ar_ready, r_valid}, 2'b10);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("sim_b_done", {b_valid, aw_ready}, 2'b01);
    idle_inputs();
  endtask

  task automatic reset_mid_read();
    ar_valid = 1'b1; ar_id = 5'h05; ar_len = 8'd7; r_ready = 1'b1;
    tick();
    ar_valid = 1'b0;
    tick();
    tick();
    check("abort_beat3", r_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_r_valid", r_valid, 1'b0);
    check("abort_ar_ready", ar_ready, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("abort_ar_back", ar_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_r", r_valid, 1'b0);
      tick();
    end
    idle_inputs();
  endtask

`ifdef SOC_DECERR_CAPTURE_EN
  task automatic capture_test();
    tick();
    check("cap_reset", err_valid, 1'b0);
    ar_valid = 1'b1; ar_addr = 64'h5000_0000; ar_len = 8'd0; ar_id = 5'd3; r_ready = 1'b1;
    tick();
    ar_valid = 1'b0;
    check("cap_first", {err_valid, err_addr}, {1'b1, 64'h5000_0000});
    tick();
    aw_valid = 1'b1; aw_addr = 64'h6000_0000; aw_id = 5'd4;
    tick();
    aw_valid = 1'b0; w_valid = 1'b1; w_last = 1'b1;
    tick();
    w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("cap_sticky", {err_valid, err_addr}, {1'b1, 64'h5000_0000});
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("cap_cleared", err_valid, 1'b0);
    ar_valid = 1'b1; ar_addr = 64'h7000_0000;
    tick();
    ar_valid = 1'b0;
    check("cap_after_clear", {err_valid, err_addr}, {1'b1, 64'h7000_0000});
    tick();
    err_clear = 1'b1; ar_valid = 1'b1; ar_addr = 64'h8000_0000;
    tick();
    err_clear = 1'b0; ar_valid = 1'b0;
    check("cap_clear_and_fault", {err_valid, err_addr}, {1'b1, 64'h8000_0000});
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    aw_valid = 1'b1; aw_addr = 64'h9000_0000; ar_valid = 1'b1; ar_addr = 64'hA000_0000;
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0;
    check("cap_aw_wins", {err_valid, err_addr}, {1'b1, 64'h9000_0000});
    w_valid = 1'b1; w_last = 1'b1;
    tick();
    w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask
`endif

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      aw_valid = ($urandom_range(0, 2) == 0);
      aw_id    = 5'($urandom_range(0, 31));
      aw_addr  = {$urandom(), $urandom()};
      w_valid  = ($urandom_range(0, 1) == 1);
      w_last   = ($urandom_range(0, 2) == 0);
      b_ready  = ($urandom_range(0, 1) == 1);
      ar_valid = ($urandom_range(0, 2) == 0);
      ar_id    = 5'($urandom_range(0, 31));
      ar_addr  = {$urandom(), $urandom()};
      ar_len   = 8'($urandom_range(0, 15));
      r_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    aw_valid = 1'b0; ar_valid = 1'b0;
    w_valid = 1'b1; w_last = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
    for (int c = 0; c < 60 && (b_exp_q.size() != 0 || exp_q.size() != 0 || w_open); c++) tick();
    check("drain_empty", {b_exp_q.size() == 0, exp_q.size() == 0}, 2'b11);
    idle_inputs();
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    aw_id = '0; ar_id = '0; aw_addr = '0; ar_addr = '0;
    idle_inputs();
    reset_dut();
    run_table();
    read_len7();
    read_len255();
    aw_ar_together();
    reset_mid_read();
`ifdef SOC_DECERR_CAPTURE_EN
    reset_dut();
    capture_test();
`endif
    reset_dut();
    run_random(3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/soc_decerr_slave.md
# soc_decerr_slave

AXI4 error-response slave on the default (unmapped) port of the SoC crossbar. Any access that misses every region of the SoC address map (Debug, ROM, CLINT, PLIC, UART, Timer, SPI, Ethernet, GPIO, DRAM) is routed here. The block completes it protocol-correctly with DECERR, so the core and debug masters never hang on a hole in the map. Read and write channels are independent and each handles one outstanding transaction.

## Interface
- `ID_WIDTH`, default 5: AXI ID width on the slave side of the crossbar; matches `IdWidthSlave`, which is `IdWidth` plus log2 of the master count.
- `DATA_WIDTH`, default 64: R data width.
- `ADDR_WIDTH`, default 64: address width.
- `ERR_DATA`, default 64'hBADC_AB1E_BADC_AB1E: constant driven on `r_data_o`.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `aw_valid_i` in 1, `aw_ready_o` out 1, `aw_id_i` in ID_WIDTH, `aw_addr_i` in ADDR_WIDTH: write address channel.
- `w_valid_i` in 1, `w_ready_o` out 1, `w_last_i` in 1: write data channel; data and strobes are ignored.
- `b_valid_o` out 1, `b_ready_i` in 1, `b_id_o` out ID_WIDTH, `b_resp_o` out 2: write response channel.
- `ar_valid_i` in 1, `ar_ready_o` out 1, `ar_id_i` in ID_WIDTH, `ar_addr_i` in ADDR_WIDTH, `ar_len_i` in 8: read address channel.
- `r_valid_o` out 1, `r_ready_i` in 1, `r_id_o` out ID_WIDTH, `r_data_o` out DATA_WIDTH, `r_resp_o` out 2, `r_last_o` out 1: read data channel.
- `err_valid_o` out 1, `err_addr_o` out ADDR_WIDTH, `err_clear_i` in 1: fault capture; only present with the macro, see Configuration.

## Operation
- Write FSM has three states: W_IDLE, W_DATA and W_RESP.
  - W_IDLE: `aw_ready_o`=1. On AW handshake, latch `aw_id_i` and go to W_DATA.
  - W_DATA: `w_ready_o`=1. Each beat is consumed. A beat with `w_last_i`=1 moves the FSM to W_RESP. `aw_len` is not checked; WLAST alone ends the burst.
  - W_RESP: `b_valid_o`=1, `b_resp_o`=2'b11, `b_id_o` = latched ID. On `b_ready_i`, return to W_IDLE.
- Read FSM has two states: R_IDLE and R_DATA.
  - R_IDLE: `ar_ready_o`=1. On AR handshake, latch the ID and `ar_len_i`, clear the 8-bit beat counter, and go to R_DATA.
  - R_DATA: `r_valid_o`=1, `r_resp_o`=2'b11, `r_data_o`=ERR_DATA. `r_last_o`=1 when counter == latched len.
  - Each `r_ready_i` increments the counter. A handshake on the last beat returns the FSM to R_IDLE.
  - A burst produces exactly len+1 beats; len=255 gives 256 beats and the counter never wraps.
- The two FSMs share no state. A simultaneous AW and AR are both accepted in the same cycle.
- W beats arriving in W_IDLE (W before AW) are not accepted: `w_ready_o`=0 until AW is taken.

## Timing
- All outputs are decoded from registered state only. There are no combinational input-to-output paths.
- Reset values: every ready/valid output is 0 during reset. `aw_ready_o` and `ar_ready_o` rise in the first cycle after `rst_i` deasserts. ID and data outputs reset to 0. `b_resp_o` and `r_resp_o` are constant 2'b11.
- Write latency: AW accepted in cycle n, so `w_ready_o`=1 from n+1. WLAST accepted in cycle m, so `b_valid_o`=1 from m+1.
- Read latency: AR accepted in cycle n, so the first R beat is valid in n+1. Sustained throughput is 1 beat/cycle while `r_ready_i`=1.
- A back-to-back AR is accepted no earlier than the cycle after the final R handshake. Minimum read occupancy is len+2 cycles.
- Valid outputs and their payload stay stable until the handshake (AXI rule); `r_id_o` is stable for the whole burst.
- Reset asserted mid-burst aborts both FSMs immediately to IDLE. No B or R is issued for the aborted transaction.

## Configuration
- `SOC_DECERR_CAPTURE_EN`, when defined: the block records the first faulting address.
  - While `err_valid_o`=0, any AW or AR handshake sets `err_valid_o` and loads `err_addr_o` from `aw_addr_i` or `ar_addr_i`. On a simultaneous AW and AR, AW wins.
  - The capture is sticky until `err_clear_i` is pulsed. If a clear and a new fault occur in the same cycle, the new fault is captured.
  - Reset clears both outputs.
- Not defined: the ports `err_valid_o`, `err_addr_o` and `err_clear_i` and their registers are absent, and the address inputs are unused.

## Structure
- The shared SoC package gains:
  - the DECERR encoding (2'b11) as a named constant;
  - a default `ERR_DATA` constant;
  - the enum types for the write FSM states and the read FSM states.
- No sub-module. The two FSMs and the optional capture register fit in one module.

## Test plan
- Reset, then AW with id 5'h13 and addr 0x0000_5000, then a 4-beat W with WLAST on beat 4 → B with id 5'h13 and resp 2'b11 one cycle after the last W, exactly once.
- AR with id 5'h02, len 7, `r_ready_i` held 1 → 8 R beats on consecutive cycles, data 0xBADCAB1EBADCAB1E, resp 2'b11, `r_last_o` only on beat 8.
- AR with len 255 and random `r_ready_i` backpressure → 256 beats, payload stable while stalled, `ar_ready_o` returns 1 only after the last handshake.
- AW and AR in the same cycle (ids 1 and 2), `b_ready_i` held 0 for 10 cycles → the read burst completes independently and B is held stable until ready.
- Assert `rst_i` at beat 3 of a len-7 read → `r_valid_o`=0 during reset, `ar_ready_o`=1 the cycle after release, no further R beats.
- With `SOC_DECERR_CAPTURE_EN` defined: read to 0x5000_0000, then write to 0x6000_0000 → `err_addr_o` is 0x5000_0000. Pulse `err_clear_i` → `err_valid_o`=0. A further read to 0x7000_0000 → `err_addr_o`=0x7000_0000.
